// File: rtl/dsd_debug_pkg.sv
// Shared types and sizing helpers for the DSD filter debug capture path.
package dsd_debug_pkg;

    typedef enum logic [2:0] {
        CAP_IDLE,
        CAP_ARMED,
        CAP_CAPTURE,
        CAP_DONE,
        CAP_READOUT
    } capture_state_t;

    // Address width for a memory of 'depth' words; never narrower than one bit.
    function automatic int get_bus_width(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/dsd_debug_capture_ctrl_if.sv
// Readout stream and debug memory ports of the capture sequencer.
interface dsd_debug_capture_ctrl_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int MEMORY_DEPTH = 16
);
    localparam int ADDR_W = dsd_debug_pkg::get_bus_width(MEMORY_DEPTH);

    // Readout stream: a word transfers on any cycle where rd_valid && rd_ready;
    // while rd_valid=1 and rd_ready=0 the producer holds rd_data/rd_last stable.
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  rd_ready;
    logic                  rd_last;

    logic                  mem_wr_en;
    logic [ADDR_W-1:0]     mem_wr_addr;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic                  mem_rd_en;
    logic [ADDR_W-1:0]     mem_rd_addr;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    modport master (
        output rd_data, rd_valid, rd_last,
        output mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_en, mem_rd_addr,
        input  rd_ready, mem_rd_data
    );

    modport slave (
        input  rd_data, rd_valid, rd_last,
        input  mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_en, mem_rd_addr,
        output rd_ready, mem_rd_data
    );

endinterface

// File: rtl/dsd_debug_capture_ctrl.sv
// Debug capture sequencer: arm, wait for trigger, store a burst of filter
// samples in the debug memory, then stream them out over valid/ready.
module dsd_debug_capture_ctrl
    import dsd_debug_pkg::*;
#(
    parameter int  DATA_WIDTH   = 32,
    parameter int  MEMORY_DEPTH = 16,
    localparam int ADDR_W       = get_bus_width(MEMORY_DEPTH),
    localparam int CNT_W        = $clog2(MEMORY_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [CNT_W-1:0]      capture_len,
    input  logic                  trig,
    input  logic [DATA_WIDTH-1:0] smp_data,
    input  logic                  smp_valid,
    input  logic                  rd_start,
    dsd_debug_capture_ctrl_if.master bus,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      captured_cnt,
    output capture_state_t        dbg_state
);

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(MEMORY_DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);

    capture_state_t   state, state_next;
    logic [CNT_W-1:0] len, len_next;
    logic [CNT_W-1:0] wr_cnt, wr_cnt_next;
    logic [CNT_W-1:0] rd_cnt, rd_cnt_next;
    logic [CNT_W-1:0] captured_next;
    logic             rd_valid, rd_valid_next;

    logic [CNT_W-1:0] len_clamped;
    logic [CNT_W-1:0] wr_cnt_inc;
    logic [CNT_W-1:0] rd_cnt_inc;
    logic             rd_last;
    logic             rd_fire;
    logic             wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic             rd_en;
    logic [ADDR_W-1:0] rd_addr;

    // A zero or oversized length request means "fill the whole memory".
    assign len_clamped = (capture_len == '0 || capture_len > DEPTH_CNT) ? DEPTH_CNT : capture_len;
    assign wr_cnt_inc  = wr_cnt + ONE_CNT;
    assign rd_cnt_inc  = rd_cnt + ONE_CNT;
    assign rd_last     = rd_valid && (rd_cnt == captured_cnt - ONE_CNT);
    assign rd_fire     = rd_valid && bus.rd_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= CAP_IDLE;
            len          <= '0;
            wr_cnt       <= '0;
            rd_cnt       <= '0;
            captured_cnt <= '0;
            rd_valid     <= 1'b0;
        end else begin
            state        <= state_next;
            len          <= len_next;
            wr_cnt       <= wr_cnt_next;
            rd_cnt       <= rd_cnt_next;
            captured_cnt <= captured_next;
            rd_valid     <= rd_valid_next;
        end
    end

    always_comb begin
        state_next    = state;
        len_next      = len;
        wr_cnt_next   = wr_cnt;
        rd_cnt_next   = rd_cnt;
        captured_next = captured_cnt;
        rd_valid_next = rd_valid;
        wr_en         = 1'b0;
        wr_addr       = wr_cnt[ADDR_W-1:0];
        rd_en         = 1'b0;
        rd_addr       = '0;

        if (abort) begin
            state_next    = CAP_IDLE;
            rd_valid_next = 1'b0;
        end else begin
            case (state)
                CAP_IDLE: begin
                    if (arm) begin
                        len_next      = len_clamped;
                        wr_cnt_next   = '0;
                        captured_next = '0;
                        state_next    = CAP_ARMED;
                    end
                end
                CAP_ARMED: begin
                    // Trigger only counts when it qualifies a real sample.
                    if (smp_valid && trig) begin
                        wr_en       = 1'b1;
                        wr_addr     = '0;
                        wr_cnt_next = ONE_CNT;
                        if (len == ONE_CNT) begin
                            captured_next = len;
                            state_next    = CAP_DONE;
                        end else begin
                            state_next = CAP_CAPTURE;
                        end
                    end
                end
                CAP_CAPTURE: begin
                    if (smp_valid) begin
                        wr_en       = 1'b1;
                        wr_cnt_next = wr_cnt_inc;
                        if (wr_cnt_inc == len) begin
                            captured_next = len;
                            state_next    = CAP_DONE;
                        end
                    end
                end
                CAP_DONE: begin
                    if (rd_start) begin
                        rd_en         = 1'b1;
                        rd_addr       = '0;
                        rd_cnt_next   = '0;
                        rd_valid_next = 1'b1;
                        state_next    = CAP_READOUT;
                    end
                end
                CAP_READOUT: begin
                    // Prefetch the next word on each accepted one so a
                    // continuously ready consumer sees one word per cycle.
                    if (rd_fire) begin
                        rd_cnt_next = rd_cnt_inc;
                        if (rd_last) begin
                            rd_valid_next = 1'b0;
                            state_next    = CAP_IDLE;
                        end else begin
                            rd_en   = 1'b1;
                            rd_addr = rd_cnt_inc[ADDR_W-1:0];
                        end
                    end
                end
                default: begin
                    state_next    = CAP_IDLE;
                    rd_valid_next = 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_wr_en   = wr_en;
    assign bus.mem_wr_addr = wr_addr;
    assign bus.mem_wr_data = smp_data;
    assign bus.mem_rd_en   = rd_en;
    assign bus.mem_rd_addr = rd_addr;
    assign bus.rd_data     = bus.mem_rd_data;
    assign bus.rd_valid    = rd_valid;
    assign bus.rd_last     = rd_last;

    assign busy      = (state != CAP_IDLE);
    assign done      = (state == CAP_DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_dsd_debug_capture_ctrl.sv
// Directed bench for the debug capture sequencer with a 1-cycle-latency RAM.
module tb_dsd_debug_capture_ctrl;
    import dsd_debug_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst_n;
    logic             arm;
    logic             abort;
    logic [CNT_W-1:0] capture_len;
    logic             trig;
    logic [DW-1:0]    smp_data;
    logic             smp_valid;
    logic             rd_start;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] captured_cnt;
    capture_state_t   dbg_state;

    int checks;
    int failures;

    logic [31:0] wr_a_q[$];
    logic [31:0] wr_d_q[$];
    logic [31:0] rd_d_q[$];
    logic        rd_l_q[$];
    logic [31:0] exp_q[$];

    logic [DW-1:0] ram [DEPTH];

    dsd_debug_capture_ctrl_if #(.DATA_WIDTH(DW), .MEMORY_DEPTH(DEPTH)) bus_if ();

    dsd_debug_capture_ctrl #(.DATA_WIDTH(DW), .MEMORY_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .arm          (arm),
        .abort        (abort),
        .capture_len  (capture_len),
        .trig         (trig),
        .smp_data     (smp_data),
        .smp_valid    (smp_valid),
        .rd_start     (rd_start),
        .bus          (bus_if),
        .busy         (busy),
        .done         (done),
        .captured_cnt (captured_cnt),
        .dbg_state    (dbg_state)
    );

    // Clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Debug memory model: write now, read data one cycle after rd_en, held otherwise.
    always @(posedge clk) begin
        if (bus_if.mem_wr_en) ram[bus_if.mem_wr_addr] <= bus_if.mem_wr_data;
        if (bus_if.mem_rd_en) bus_if.mem_rd_data <= ram[bus_if.mem_rd_addr];
    end

    // Driver tasks: inputs change at negedge, observations 1ns later.
    task automatic tick();
        #1;
        if (bus_if.mem_wr_en === 1'b1) begin
            wr_a_q.push_back(32'(bus_if.mem_wr_addr));
            wr_d_q.push_back(bus_if.mem_wr_data);
        end
        if (bus_if.rd_valid === 1'b1 && bus_if.rd_ready === 1'b1) begin
            rd_d_q.push_back(bus_if.rd_data);
            rd_l_q.push_back(bus_if.rd_last);
        end
        @(negedge clk);
    endtask

    task automatic clear_obs();
        wr_a_q.delete(); wr_d_q.delete(); rd_d_q.delete(); rd_l_q.delete(); exp_q.delete();
    endtask

    task automatic arm_capture(input logic [CNT_W-1:0] l);
        arm = 1'b1; capture_len = l;
        tick();
        arm = 1'b0;
    endtask

    task automatic drain();
        bus_if.rd_ready = 1'b1;
        for (int n = 0; n < 40 && busy; n++) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        checks++; if (dbg_state !== CAP_IDLE) begin failures++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, CAP_IDLE); end
        checks++; if ({busy, done, bus_if.rd_valid, bus_if.rd_last, bus_if.mem_wr_en, bus_if.mem_rd_en} !== 6'b0) begin
            failures++; $display("FAIL reset_outputs: got %b expected 000000", {busy, done, bus_if.rd_valid, bus_if.rd_last, bus_if.mem_wr_en, bus_if.mem_rd_en});
        end
        checks++; if (captured_cnt !== '0) begin failures++; $display("FAIL reset_captured_cnt: got %0d expected 0", captured_cnt); end
        @(negedge clk);
    endtask

    task automatic test_basic_capture();
        clear_obs();
        arm_capture(4);
        for (int i = 0; i < 8; i++) begin
            smp_valid = 1'b1; smp_data = 32'h10 + 32'(i); trig = (i == 2);
            tick();
        end
        smp_valid = 1'b0; trig = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h12 + 32'(i));
        checks++; if (wr_d_q.size() != 4) begin failures++; $display("FAIL basic_wr_count: got %0d expected 4", wr_d_q.size()); end
        else for (int i = 0; i < 4; i++) begin
            checks++; if (wr_a_q[i] !== 32'(i) || wr_d_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL basic_wr[%0d]: got addr %0d data %h expected addr %0d data %h", i, wr_a_q[i], wr_d_q[i], i, exp_q[i]);
            end
        end
        checks++; if (done !== 1'b1 || captured_cnt !== 5'd4) begin failures++; $display("FAIL basic_done: got done %b cnt %0d expected done 1 cnt 4", done, captured_cnt); end
        rd_start = 1'b1; bus_if.rd_ready = 1'b1;
        #1;
        checks++; if (bus_if.mem_rd_en !== 1'b1 || bus_if.mem_rd_addr !== '0 || bus_if.rd_valid !== 1'b0) begin
            failures++; $display("FAIL basic_first_read: got rd_en %b addr %0d rd_valid %b expected 1 0 0", bus_if.mem_rd_en, bus_if.mem_rd_addr, bus_if.rd_valid);
        end
        tick();
        rd_start = 1'b0;
        #1;
        checks++; if (bus_if.rd_valid !== 1'b1 || bus_if.rd_data !== 32'h12) begin
            failures++; $display("FAIL basic_first_word: got valid %b data %h expected valid 1 data 00000012", bus_if.rd_valid, bus_if.rd_data);
        end
        drain();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_readout_end: got busy %b expected 0", busy); end
        checks++; if (rd_d_q.size() != 4) begin failures++; $display("FAIL basic_rd_count: got %0d expected 4", rd_d_q.size()); end
        else for (int i = 0; i < 4; i++) begin
            checks++; if (rd_d_q[i] !== exp_q[i] || rd_l_q[i] !== (i == 3)) begin
                failures++; $display("FAIL basic_rd[%0d]: got data %h last %b expected data %h last %b", i, rd_d_q[i], rd_l_q[i], exp_q[i], (i == 3));
            end
        end
    endtask

    task automatic test_gapped_backpressure();
        logic          stalled;
        logic [DW-1:0] held_d;
        logic          held_l;
        clear_obs();
        arm_capture(3);
        for (int i = 0; i < 5; i++) begin
            smp_valid = (i % 2 == 0); trig = (i == 0); smp_data = 32'h20 + 32'(i);
            tick();
        end
        smp_valid = 1'b0; trig = 1'b0;
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h20 + 32'(2 * i));
        checks++; if (wr_d_q.size() != 3) begin failures++; $display("FAIL gap_wr_count: got %0d expected 3", wr_d_q.size()); end
        else for (int i = 0; i < 3; i++) begin
            checks++; if (wr_a_q[i] !== 32'(i) || wr_d_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL gap_wr[%0d]: got addr %0d data %h expected addr %0d data %h", i, wr_a_q[i], wr_d_q[i], i, exp_q[i]);
            end
        end
        checks++; if (captured_cnt !== 5'd3) begin failures++; $display("FAIL gap_captured_cnt: got %0d expected 3", captured_cnt); end
        rd_start = 1'b1; bus_if.rd_ready = 1'b0;
        tick();
        rd_start = 1'b0;
        stalled = 1'b0; held_d = '0; held_l = 1'b0;
        for (int c = 0; c < 30 && busy; c++) begin
            bus_if.rd_ready = (c % 2 == 1);
            #1;
            if (stalled) begin
                checks++; if (bus_if.rd_valid !== 1'b1 || bus_if.rd_data !== held_d || bus_if.rd_last !== held_l) begin
                    failures++; $display("FAIL gap_hold: got valid %b data %h last %b expected valid 1 data %h last %b", bus_if.rd_valid, bus_if.rd_data, bus_if.rd_last, held_d, held_l);
                end
            end
            if (bus_if.rd_valid === 1'b1 && !bus_if.rd_ready) begin
                checks++; if (bus_if.mem_rd_en !== 1'b0) begin failures++; $display("FAIL gap_stall_read: got rd_en %b expected 0", bus_if.mem_rd_en); end
            end
            stalled = bus_if.rd_valid && !bus_if.rd_ready;
            held_d  = bus_if.rd_data;
            held_l  = bus_if.rd_last;
            tick();
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL gap_readout_end: got busy %b expected 0", busy); end
        checks++; if (rd_d_q.size() != 3) begin failures++; $display("FAIL gap_rd_count: got %0d expected 3", rd_d_q.size()); end
        else for (int i = 0; i < 3; i++) begin
            checks++; if (rd_d_q[i] !== exp_q[i] || rd_l_q[i] !== (i == 2)) begin
                failures++; $display("FAIL gap_rd[%0d]: got data %h last %b expected data %h last %b", i, rd_d_q[i], rd_l_q[i], exp_q[i], (i == 2));
            end
        end
    endtask

    task automatic test_length_clamp();
        logic [CNT_W-1:0] lens[2];
        lens[0] = 5'd0; lens[1] = 5'd17;
        for (int k = 0; k < 2; k++) begin
            clear_obs();
            arm_capture(lens[k]);
            for (int i = 0; i < 20; i++) begin
                smp_valid = 1'b1; trig = (i == 0); smp_data = 32'h100 + 32'(k * 32'h1000) + 32'(i);
                tick();
            end
            smp_valid = 1'b0; trig = 1'b0;
            checks++; if (wr_d_q.size() != 16) begin failures++; $display("FAIL clamp%0d_wr_count: got %0d expected 16", k, wr_d_q.size()); end
            else for (int i = 0; i < 16; i++) begin
                checks++; if (wr_a_q[i] !== 32'(i) || wr_d_q[i] !== 32'h100 + 32'(k * 32'h1000) + 32'(i)) begin
                    failures++; $display("FAIL clamp%0d_wr[%0d]: got addr %0d data %h expected addr %0d data %h", k, i, wr_a_q[i], wr_d_q[i], i, 32'h100 + 32'(k * 32'h1000) + 32'(i));
                end
            end
            checks++; if (done !== 1'b1 || captured_cnt !== 5'd16) begin failures++; $display("FAIL clamp%0d_done: got done %b cnt %0d expected done 1 cnt 16", k, done, captured_cnt); end
            abort = 1'b1;
            tick();
            abort = 1'b0;
            checks++; if (busy !== 1'b0 || captured_cnt !== 5'd16) begin failures++; $display("FAIL clamp%0d_abort: got busy %b cnt %0d expected busy 0 cnt 16", k, busy, captured_cnt); end
        end
    endtask

    task automatic test_trigger_gating();
        clear_obs();
        arm_capture(2);
        trig = 1'b1; smp_valid = 1'b0;
        repeat (2) tick();
        trig = 1'b0;
        for (int i = 0; i < 5; i++) begin
            smp_valid = 1'b1; smp_data = 32'h40 + 32'(i);
            tick();
        end
        checks++; if (wr_d_q.size() != 0) begin failures++; $display("FAIL gate_no_write: got %0d writes expected 0", wr_d_q.size()); end
        checks++; if (dbg_state !== CAP_ARMED) begin failures++; $display("FAIL gate_armed: got %0d expected %0d", dbg_state, CAP_ARMED); end
        trig = 1'b1; smp_data = 32'hAA;
        #1;
        checks++; if (bus_if.mem_wr_en !== 1'b1 || bus_if.mem_wr_addr !== '0 || bus_if.mem_wr_data !== 32'hAA) begin
            failures++; $display("FAIL gate_first_write: got en %b addr %0d data %h expected 1 0 000000aa", bus_if.mem_wr_en, bus_if.mem_wr_addr, bus_if.mem_wr_data);
        end
        tick();
        trig = 1'b0; smp_data = 32'hBB;
        tick();
        smp_valid = 1'b0;
        checks++; if (dbg_state !== CAP_DONE || captured_cnt !== 5'd2 || wr_d_q.size() != 2) begin
            failures++; $display("FAIL gate_done: got state %0d cnt %0d writes %0d expected state %0d cnt 2 writes 2", dbg_state, captured_cnt, wr_d_q.size(), CAP_DONE);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_abort();
        arm = 1'b1; abort = 1'b1; capture_len = 5'd4;
        tick();
        arm = 1'b0; abort = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_arm_clash: got busy %b expected 0", busy); end
        clear_obs();
        arm_capture(8);
        smp_valid = 1'b1; trig = 1'b1; smp_data = 32'h50;
        tick();
        trig = 1'b0; smp_data = 32'h51;
        tick();
        abort = 1'b1; smp_data = 32'h52;
        #1;
        checks++; if (bus_if.mem_wr_en !== 1'b0 || bus_if.mem_rd_en !== 1'b0) begin
            failures++; $display("FAIL abort_strobes: got wr %b rd %b expected 0 0", bus_if.mem_wr_en, bus_if.mem_rd_en);
        end
        tick();
        abort = 1'b0; smp_valid = 1'b0;
        checks++; if (dbg_state !== CAP_IDLE || busy !== 1'b0) begin failures++; $display("FAIL abort_idle: got state %0d busy %b expected %0d 0", dbg_state, busy, CAP_IDLE); end
        checks++; if (wr_d_q.size() != 2 || captured_cnt !== 5'd0) begin failures++; $display("FAIL abort_counts: got writes %0d cnt %0d expected 2 0", wr_d_q.size(), captured_cnt); end
        rd_start = 1'b1; bus_if.rd_ready = 1'b1;
        #1;
        checks++; if (bus_if.mem_rd_en !== 1'b0) begin failures++; $display("FAIL abort_rd_start: got rd_en %b expected 0", bus_if.mem_rd_en); end
        tick();
        rd_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus_if.rd_valid !== 1'b0) begin failures++; $display("FAIL abort_no_valid[%0d]: got %b expected 0", i, bus_if.rd_valid); end
            tick();
        end
    endtask

    task automatic test_arm_in_readout();
        clear_obs();
        arm_capture(2);
        smp_valid = 1'b1; trig = 1'b1; smp_data = 32'h30;
        tick();
        trig = 1'b0; smp_data = 32'h31;
        tick();
        smp_valid = 1'b0;
        rd_start = 1'b1; bus_if.rd_ready = 1'b0;
        tick();
        rd_start = 1'b0;
        arm = 1'b1; capture_len = 5'd5;
        tick();
        arm = 1'b0;
        checks++; if (dbg_state !== CAP_READOUT) begin failures++; $display("FAIL rdarm_state: got %0d expected %0d", dbg_state, CAP_READOUT); end
        drain();
        checks++; if (busy !== 1'b0 || captured_cnt !== 5'd2) begin failures++; $display("FAIL rdarm_end: got busy %b cnt %0d expected 0 2", busy, captured_cnt); end
        checks++; if (rd_d_q.size() != 2) begin failures++; $display("FAIL rdarm_rd_count: got %0d expected 2", rd_d_q.size()); end
        else begin
            checks++; if (rd_d_q[0] !== 32'h30 || rd_l_q[0] !== 1'b0 || rd_d_q[1] !== 32'h31 || rd_l_q[1] !== 1'b1) begin
                failures++; $display("FAIL rdarm_words: got %h/%b %h/%b expected 00000030/0 00000031/1", rd_d_q[0], rd_l_q[0], rd_d_q[1], rd_l_q[1]);
            end
        end
    endtask

    task automatic test_reset_mid_readout();
        clear_obs();
        arm_capture(4);
        for (int i = 0; i < 4; i++) begin
            smp_valid = 1'b1; trig = (i == 0); smp_data = 32'h60 + 32'(i);
            tick();
        end
        smp_valid = 1'b0; trig = 1'b0;
        rd_start = 1'b1; bus_if.rd_ready = 1'b1;
        tick();
        rd_start = 1'b0;
        tick();
        bus_if.rd_ready = 1'b0; rst_n = 1'b0;
        tick();
        rst_n = 1'b1; bus_if.rd_ready = 1'b1;
        #1;
        checks++; if (bus_if.rd_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL rst_mid_flags: got valid %b busy %b done %b expected 0 0 0", bus_if.rd_valid, busy, done);
        end
        checks++; if (captured_cnt !== '0) begin failures++; $display("FAIL rst_mid_cnt: got %0d expected 0", captured_cnt); end
        checks++; if (bus_if.mem_rd_en !== 1'b0 || bus_if.mem_wr_en !== 1'b0) begin
            failures++; $display("FAIL rst_mid_strobes: got rd %b wr %b expected 0 0", bus_if.mem_rd_en, bus_if.mem_wr_en);
        end
        checks++; if (rd_d_q.size() != 1 || rd_d_q[0] !== 32'h60) begin failures++; $display("FAIL rst_mid_words: got %0d words expected 1 (00000060)", rd_d_q.size()); end
        tick();
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; arm = 1'b0; abort = 1'b0; capture_len = '0; trig = 1'b0;
        smp_data = '0; smp_valid = 1'b0; rd_start = 1'b0; bus_if.rd_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic_capture();
        test_gapped_backpressure();
        test_length_clamp();
        test_trigger_gating();
        test_abort();
        test_arm_in_readout();
        test_reset_mid_readout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
